// File: rtl/hp_op_sequencer_if.sv
// Request, datapath and response signals of the hp FPU operation sequencer.
// The slave modport is the sequencer. The master modport is the core side,
// which also hosts the combinational datapath.
interface hp_op_sequencer_if #(
  parameter int unsigned num_bits = 16,
  parameter int unsigned CNT_W    = 16
);
  logic                req_valid;
  logic                req_ready;
  logic [num_bits-1:0] req_a;
  logic [num_bits-1:0] req_b;
  logic [2:0]          req_op;
  logic [num_bits-1:0] dp_a;
  logic [num_bits-1:0] dp_b;
  logic [2:0]          dp_op;
  logic [num_bits-1:0] dp_res;
  logic [5:0]          dp_flags;
  logic                rng_step;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [num_bits-1:0] rsp_res;
  logic [5:0]          rsp_flags;
  logic                rsp_unsupported;
  logic                busy;
  logic [CNT_W-1:0]    op_count;

  modport slave (
    input  req_valid, req_a, req_b, req_op, dp_res, dp_flags, rsp_ready,
    output req_ready, dp_a, dp_b, dp_op, rng_step, rsp_valid, rsp_res, rsp_flags,
           rsp_unsupported, busy, op_count
  );

  modport master (
    output req_valid, req_a, req_b, req_op, dp_res, dp_flags, rsp_ready,
    input  req_ready, dp_a, dp_b, dp_op, rng_step, rsp_valid, rsp_res, rsp_flags,
           rsp_unsupported, busy, op_count
  );
endinterface

// File: rtl/hp_op_sequencer.sv
// Sequencer between the core and the combinational hp FPU datapath.
// It accepts one operation at a time and holds it on the datapath for EXEC_CYCLES cycles.
// It then captures the result and flags and presents them as a response.
// Unimplemented opcodes are squashed to a canonical QNaN.
// The SR RNG steps once per completed SR operation.
module hp_op_sequencer #(
  parameter int unsigned num_bits    = 16,
  parameter int unsigned EXEC_CYCLES = 1,  // must be >= 1
  parameter logic [7:0]  OP_MASK     = 8'b0011_0000,
  parameter int unsigned CNT_W       = 16
) (
  input logic                 clk,
  input logic                 reset,
  hp_op_sequencer_if.slave    bus
);

  localparam int unsigned CntW = $clog2(EXEC_CYCLES + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(EXEC_CYCLES - 1);
  localparam logic [num_bits-1:0] CanonQnan =
      (num_bits == 32) ? num_bits'(32'h7FC0_0000) : num_bits'(32'h0000_7E00);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [num_bits-1:0] dp_a_q, dp_a_d;
  logic [num_bits-1:0] dp_b_q, dp_b_d;
  logic [2:0]          dp_op_q, dp_op_d;
  logic [num_bits-1:0] rsp_res_q, rsp_res_d;
  logic [5:0]          rsp_flags_q, rsp_flags_d;
  logic                rsp_unsup_q, rsp_unsup_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rng_step_q, rng_step_d;
  logic [CNT_W-1:0]    op_count_q, op_count_d;

  logic req_ready;
  logic accept;
  logic supported;

  // Ready while idle, or while a response is being consumed this edge (back-to-back).
  assign req_ready = (state_q == StIdle) | ((state_q == StDone) & bus.rsp_ready);
  assign accept    = bus.req_valid & req_ready;
  assign supported = OP_MASK[dp_op_q];

  // Next state: FSM sequencing, operand latch, capture and handoff accounting.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dp_a_d      = dp_a_q;
    dp_b_d      = dp_b_q;
    dp_op_d     = dp_op_q;
    rsp_res_d   = rsp_res_q;
    rsp_flags_d = rsp_flags_q;
    rsp_unsup_d = rsp_unsup_q;
    rsp_valid_d = rsp_valid_q;
    rng_step_d  = 1'b0;
    op_count_d  = op_count_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) state_d = StExec;
      end
      StExec: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d     = StDone;
          rsp_valid_d = 1'b1;
          if (supported) begin
            rsp_res_d   = bus.dp_res;
            rsp_flags_d = bus.dp_flags;
            rsp_unsup_d = 1'b0;
            rng_step_d  = dp_op_q[0];
          end else begin
            rsp_res_d   = CanonQnan;
            rsp_flags_d = 6'b000010;
            rsp_unsup_d = 1'b1;
          end
        end
      end
      StDone: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = bus.req_valid ? StExec : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Request inputs are only ever sampled here.
    if (accept) begin
      dp_a_d  = bus.req_a;
      dp_b_d  = bus.req_b;
      dp_op_d = bus.req_op;
      cnt_d   = CntInit;
    end
  end

  // State registers with synchronous reset; reset drops any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      dp_op_q     <= '0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
      rsp_unsup_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rng_step_q  <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      dp_op_q     <= dp_op_d;
      rsp_res_q   <= rsp_res_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_unsup_q <= rsp_unsup_d;
      rsp_valid_q <= rsp_valid_d;
      rng_step_q  <= rng_step_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.req_ready       = req_ready;
  assign bus.dp_a            = dp_a_q;
  assign bus.dp_b            = dp_b_q;
  assign bus.dp_op           = dp_op_q;
  assign bus.rng_step        = rng_step_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_res         = rsp_res_q;
  assign bus.rsp_flags       = rsp_flags_q;
  assign bus.rsp_unsupported = rsp_unsup_q;
  assign bus.busy            = (state_q != StIdle);
  assign bus.op_count        = op_count_q;

endmodule

// File: tb/tb_hp_op_sequencer.sv
// Directed bench for hp_op_sequencer.
// Instance A uses EXEC_CYCLES=1 and a 16-bit count.
// Instance B uses EXEC_CYCLES=4 and a 4-bit count, so the wrap is reached quickly.
module tb_hp_op_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hp_op_sequencer_if #(.num_bits(16), .CNT_W(16)) bus_a ();
  hp_op_sequencer_if #(.num_bits(16), .CNT_W(4))  bus_b ();

  hp_op_sequencer #(
    .num_bits(16), .EXEC_CYCLES(1), .OP_MASK(8'b0011_0000), .CNT_W(16)
  ) u_dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a.slave)
  );

  hp_op_sequencer #(
    .num_bits(16), .EXEC_CYCLES(4), .OP_MASK(8'b0011_0000), .CNT_W(4)
  ) u_dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus_a.req_valid = 0; bus_a.req_a = 0; bus_a.req_b = 0; bus_a.req_op = 0;
    bus_a.dp_res = 0; bus_a.dp_flags = 0; bus_a.rsp_ready = 0;
    bus_b.req_valid = 0; bus_b.req_a = 0; bus_b.req_b = 0; bus_b.req_op = 0;
    bus_b.dp_res = 0; bus_b.dp_flags = 0; bus_b.rsp_ready = 0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_rsp_valid", bus_a.rsp_valid, 0);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_req_ready", bus_a.req_ready, 1);
    chk("rst_op_count", bus_a.op_count, 0);
    chk("rst_dp_a", bus_a.dp_a, 0);
    chk("rst_rsp_res", bus_a.rsp_res, 0);
    chk("rst_rng_step", bus_a.rng_step, 0);

    // 1. MUL_RN 3C00 * 4000 -> 4000, normal
    bus_a.req_valid = 1; bus_a.req_a = 16'h3C00; bus_a.req_b = 16'h4000; bus_a.req_op = 3'b100;
    bus_a.dp_res = 16'h4000; bus_a.dp_flags = 6'b000100;
    tick();  // accept
    bus_a.req_valid = 0;
    chk("t1_busy", bus_a.busy, 1);
    chk("t1_valid_early", bus_a.rsp_valid, 0);
    chk("t1_req_ready_exec", bus_a.req_ready, 0);
    chk("t1_dp_a", bus_a.dp_a, 16'h3C00);
    chk("t1_dp_op", bus_a.dp_op, 3'b100);
    tick();  // capture
    chk("t1_valid", bus_a.rsp_valid, 1);
    chk("t1_res", bus_a.rsp_res, 16'h4000);
    chk("t1_flags", bus_a.rsp_flags, 6'b000100);
    chk("t1_unsup", bus_a.rsp_unsupported, 0);
    chk("t1_rng", bus_a.rng_step, 0);
    bus_a.rsp_ready = 1;
    tick();  // handoff
    bus_a.rsp_ready = 0;
    chk("t1_valid_clr", bus_a.rsp_valid, 0);
    chk("t1_count", bus_a.op_count, 1);
    chk("t1_idle", bus_a.busy, 0);
    chk("t1_rng_after", bus_a.rng_step, 0);

    // 2. MUL_SR: one rng_step pulse in the cycle after capture
    bus_a.req_valid = 1; bus_a.req_a = 16'h3555; bus_a.req_b = 16'h3555; bus_a.req_op = 3'b101;
    bus_a.dp_res = 16'h2F1C; bus_a.dp_flags = 6'b000100;
    tick();  // accept
    bus_a.req_valid = 0;
    chk("t2_rng_accept", bus_a.rng_step, 0);
    tick();  // capture
    chk("t2_valid", bus_a.rsp_valid, 1);
    chk("t2_rng_pulse", bus_a.rng_step, 1);
    chk("t2_res", bus_a.rsp_res, 16'h2F1C);
    chk("t2_unsup", bus_a.rsp_unsupported, 0);
    tick();
    chk("t2_rng_low", bus_a.rng_step, 0);
    chk("t2_valid_hold", bus_a.rsp_valid, 1);
    bus_a.rsp_ready = 1;
    tick();
    bus_a.rsp_ready = 0;
    chk("t2_rng_low2", bus_a.rng_step, 0);
    chk("t2_count", bus_a.op_count, 2);

    // 3. ADD_RN is unimplemented: squashed to canonical QNaN
    bus_a.req_valid = 1; bus_a.req_a = 16'h1234; bus_a.req_b = 16'h5678; bus_a.req_op = 3'b000;
    bus_a.dp_res = 16'hABCD; bus_a.dp_flags = 6'b111111;
    tick();  // accept
    bus_a.req_valid = 0;
    tick();  // capture
    chk("t3_valid", bus_a.rsp_valid, 1);
    chk("t3_res", bus_a.rsp_res, 16'h7E00);
    chk("t3_flags", bus_a.rsp_flags, 6'b000010);
    chk("t3_unsup", bus_a.rsp_unsupported, 1);
    chk("t3_rng", bus_a.rng_step, 0);

    // 4. Backpressure with a waiting request
    bus_a.req_valid = 1; bus_a.req_a = 16'h4000; bus_a.req_b = 16'h4000; bus_a.req_op = 3'b100;
    bus_a.dp_res = 16'h4400; bus_a.dp_flags = 6'b000100;
    for (int i = 0; i < 10; i++) begin
      chk("t4_req_ready", bus_a.req_ready, 0);
      tick();
      chk("t4_valid", bus_a.rsp_valid, 1);
      chk("t4_res", bus_a.rsp_res, 16'h7E00);
      chk("t4_flags", bus_a.rsp_flags, 6'b000010);
      chk("t4_dp_a", bus_a.dp_a, 16'h1234);
      chk("t4_count", bus_a.op_count, 2);
    end
    bus_a.rsp_ready = 1;
    #1;
    chk("t4_req_ready_comb", bus_a.req_ready, 1);
    tick();  // handoff + accept
    bus_a.rsp_ready = 0; bus_a.req_valid = 0;
    chk("t4_count_inc", bus_a.op_count, 3);
    chk("t4_busy", bus_a.busy, 1);
    chk("t4_valid_clr", bus_a.rsp_valid, 0);
    chk("t4_dp_a_new", bus_a.dp_a, 16'h4000);
    chk("t4_dp_op_new", bus_a.dp_op, 3'b100);
    tick();  // capture
    chk("t4_res_new", bus_a.rsp_res, 16'h4400);
    chk("t4_unsup_new", bus_a.rsp_unsupported, 0);
    bus_a.rsp_ready = 1;
    tick();
    bus_a.rsp_ready = 0;
    chk("t4_count_final", bus_a.op_count, 4);

    // 6a. Reset during EXEC of MUL_SR drops the op
    bus_a.req_valid = 1; bus_a.req_a = 16'h3555; bus_a.req_b = 16'h3555; bus_a.req_op = 3'b101;
    tick();  // accept
    bus_a.req_valid = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_valid", bus_a.rsp_valid, 0);
    chk("t6_rng", bus_a.rng_step, 0);
    chk("t6_busy", bus_a.busy, 0);
    chk("t6_count", bus_a.op_count, 0);
    chk("t6_dp_a", bus_a.dp_a, 0);
    chk("t6_dp_op", bus_a.dp_op, 0);
    tick();
    chk("t6_valid2", bus_a.rsp_valid, 0);
    chk("t6_rng2", bus_a.rng_step, 0);

    // 5. EXEC_CYCLES=4: latency 4 edges, operands held while req_a toggles
    bus_b.req_valid = 1; bus_b.req_a = 16'h3C00; bus_b.req_b = 16'h4000; bus_b.req_op = 3'b100;
    bus_b.dp_res = 16'h4000; bus_b.dp_flags = 6'b000100;
    tick();  // accept
    bus_b.req_valid = 0;
    for (int e = 1; e <= 3; e++) begin
      bus_b.req_a = ~bus_b.req_a; bus_b.req_b = 16'h0000; bus_b.req_op = 3'b011;
      tick();
      chk("t5_valid_early", bus_b.rsp_valid, 0);
      chk("t5_dp_a", bus_b.dp_a, 16'h3C00);
      chk("t5_dp_b", bus_b.dp_b, 16'h4000);
      chk("t5_dp_op", bus_b.dp_op, 3'b100);
    end
    tick();  // fourth edge: capture
    chk("t5_valid", bus_b.rsp_valid, 1);
    chk("t5_res", bus_b.rsp_res, 16'h4000);
    chk("t5_dp_a_done", bus_b.dp_a, 16'h3C00);
    bus_b.rsp_ready = 1;
    tick();
    bus_b.rsp_ready = 0;
    chk("t5_count", bus_b.op_count, 1);

    // 6b. op_count wraps from all-ones to zero (4-bit counter)
    bus_b.req_op = 3'b100;
    for (int n = 2; n <= 16; n++) begin
      bus_b.req_valid = 1;
      tick();
      bus_b.req_valid = 0;
      tick(); tick(); tick(); tick();
      chk("t6b_valid", bus_b.rsp_valid, 1);
      bus_b.rsp_ready = 1;
      tick();
      bus_b.rsp_ready = 0;
      if (n == 15) chk("t6b_count_max", bus_b.op_count, 4'hF);
    end
    chk("t6b_count_wrap", bus_b.op_count, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
